// File: rtl/switch_node_if.sv
// Token/credit bundle between a switch_node and its five neighbours plus its
// static routing configuration.
`ifndef PATH_WIDTH
`define PATH_WIDTH 64
`endif

interface switch_node_if;
   logic [14:0]          conf;
   logic [`PATH_WIDTH:0] d_in_N, d_in_E, d_in_S, d_in_W, d_in_NW;
   logic                 c_in_N, c_in_E, c_in_S, c_in_W, c_in_SE;
   logic [`PATH_WIDTH:0] d_out_N, d_out_E, d_out_S, d_out_W, d_out_SE;
   logic                 c_out_N, c_out_E, c_out_S, c_out_W, c_out_NW;
   logic                 err;

   modport master (
      output conf,
      output d_in_N, d_in_E, d_in_S, d_in_W, d_in_NW,
      output c_in_N, c_in_E, c_in_S, c_in_W, c_in_SE,
      input  d_out_N, d_out_E, d_out_S, d_out_W, d_out_SE,
      input  c_out_N, c_out_E, c_out_S, c_out_W, c_out_NW,
      input  err
   );

   modport slave (
      input  conf,
      input  d_in_N, d_in_E, d_in_S, d_in_W, d_in_NW,
      input  c_in_N, c_in_E, c_in_S, c_in_W, c_in_SE,
      output d_out_N, d_out_E, d_out_S, d_out_W, d_out_SE,
      output c_out_N, c_out_E, c_out_S, c_out_W, c_out_NW,
      output err
   );
endinterface

// File: rtl/switch_node.sv
// Credit-flow-controlled DySER switch: five 1-entry input buffers (N,E,S,W,NW)
// routed by a static select word to five outputs (N,E,S,W,SE), fan-out allowed.
`ifndef PATH_WIDTH
`define PATH_WIDTH 64
`endif

module switch_node #(
   parameter int ID = 0
) (
   input  logic          clk,
   input  logic          rst,
   switch_node_if.slave  bus
);
   localparam int PW = `PATH_WIDTH;
   localparam int NP = 5;

   // ID only tags instances for debug; it shapes no hardware.
   if (ID < 0) begin : g_negative_id
   end

   logic [PW:0]   w_d_in [NP];
   logic [NP-1:0] w_vin;
   logic [NP-1:0] w_c_in;
   logic [2:0]    w_sel [NP];
   logic [NP-1:0] w_dest [NP];
   logic [NP-1:0] w_fire;
   logic [NP-1:0] w_ofire;
   logic [PW-1:0] w_odata [NP];
   logic [NP-1:0] w_drop;
   logic [NP-1:0] w_cred_err;

   logic [NP-1:0] r_full;
   logic [PW-1:0] r_data [NP];
   logic [PW:0]   r_d_out [NP];
   logic [NP-1:0] r_cred;
   logic [NP-1:0] r_c_out;
   logic          r_err;

   assign w_d_in[0] = bus.d_in_N;
   assign w_d_in[1] = bus.d_in_E;
   assign w_d_in[2] = bus.d_in_S;
   assign w_d_in[3] = bus.d_in_W;
   assign w_d_in[4] = bus.d_in_NW;
   assign w_c_in    = {bus.c_in_SE, bus.c_in_W, bus.c_in_S, bus.c_in_E, bus.c_in_N};
   assign w_sel[0]  = bus.conf[2:0];
   assign w_sel[1]  = bus.conf[5:3];
   assign w_sel[2]  = bus.conf[8:6];
   assign w_sel[3]  = bus.conf[11:9];
   assign w_sel[4]  = bus.conf[14:12];

   // An input fires only when every output it feeds holds a credit.
   always_comb begin
      for (int i = 0; i < NP; i++) begin
         w_vin[i]  = w_d_in[i][0];
         w_dest[i] = '0;
         for (int o = 0; o < NP; o++) begin
            w_dest[i][o] = (w_sel[o] == 3'(i));
         end
         w_fire[i] = r_full[i] && ((w_dest[i] & ~r_cred) == '0);
      end
   end

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      for (int o = 0; o < NP; o++) begin
         w_ofire[o] = 1'b0;
         w_odata[o] = r_data[0];
         for (int i = 0; i < NP; i++) begin
            if (w_dest[i][o]) begin
               w_ofire[o] = w_fire[i];
               w_odata[o] = r_data[i];
            end
         end
      end
      w_drop     = w_vin & r_full;
      w_cred_err = w_c_in & r_cred & ~w_ofire;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_full  <= '0;
         r_cred  <= '1;
         r_c_out <= '0;
         r_err   <= 1'b0;
         for (int o = 0; o < NP; o++) r_d_out[o] <= '0;
      end else begin
         r_c_out <= w_fire;
         for (int i = 0; i < NP; i++) begin
            if (w_fire[i])               r_full[i] <= 1'b0;
            if (w_vin[i] && !r_full[i])  r_full[i] <= 1'b1;
         end
         for (int o = 0; o < NP; o++) begin
            r_d_out[o][0] <= w_ofire[o];
            if (w_ofire[o]) r_d_out[o][PW:1] <= w_odata[o];
            r_cred[o] <= (r_cred[o] & ~w_ofire[o]) | w_c_in[o];
         end
         if ((|w_drop) || (|w_cred_err)) r_err <= 1'b1;
      end
   end

   // NOTE: buffer payload is not reset; the full flags alone decide whether it is meaningful.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NP; i++) begin
         if (w_vin[i] && !r_full[i]) r_data[i] <= w_d_in[i][PW:1];
      end
   end

   assign bus.d_out_N  = r_d_out[0];
   assign bus.d_out_E  = r_d_out[1];
   assign bus.d_out_S  = r_d_out[2];
   assign bus.d_out_W  = r_d_out[3];
   assign bus.d_out_SE = r_d_out[4];
   assign bus.c_out_N  = r_c_out[0];
   assign bus.c_out_E  = r_c_out[1];
   assign bus.c_out_S  = r_c_out[2];
   assign bus.c_out_W  = r_c_out[3];
   assign bus.c_out_NW = r_c_out[4];
   assign bus.err      = r_err;
endmodule
